counter_sweep_ctrl: RTL and testbench

//  Sequencer for the 4-bit up/down counter block: drives its enable/set/set_value/up_down

---
 rtl/counter_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_ctrl
//  Description : Sequences an attached up/down counter through programmed
//                ramps (optionally triangular) for a number of passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int REPS_W  = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_end,
  input  logic               cfg_bounce,
  input  logic [REPS_W-1:0]  cfg_reps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [WIDTH-1:0]   cnt_count,
  output logic               cnt_enable,
  output logic               cnt_set,
  output logic [WIDTH-1:0]   cnt_set_value,
  output logic               cnt_up_down,
  output logic               busy,
  output logic               done,
  output logic [REPS_W-1:0]  sweep_idx
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_RUN     = 3'd3,
    S_LEG_END = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_start_val;
  logic [WIDTH-1:0]   r_end_val;
  logic               r_bounce;
  logic [REPS_W-1:0]  r_reps;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_up;
  logic               r_leg_back;
  logic [WIDTH-1:0]   r_target;
  logic [DWELL_W-1:0] r_timer;
  logic [REPS_W-1:0]  r_sweep_idx;
  logic [REPS_W-1:0]  w_idx_inc;
  logic               w_pass_last;

  assign w_idx_inc   = r_sweep_idx + {{(REPS_W-1){1'b0}}, 1'b1};
  assign w_pass_last = (r_reps != '0) && (w_idx_inc == r_reps);
  assign sweep_idx   = r_sweep_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    busy          = (r_state != S_IDLE);
    cnt_set       = 1'b0;
    cnt_set_value = '0;
    cnt_enable    = 1'b0;
    done          = 1'b0;
    cnt_up_down   = (r_state != S_IDLE) & (r_up ^ r_leg_back);
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = S_LOAD;
      end
      S_LOAD: begin
        cnt_set       = 1'b1;
        cnt_set_value = r_start_val;
        w_next        = S_CHECK;
      end
      S_CHECK: begin
        // count feedback only steers the next state, never an output
        if (cnt_count == r_target) w_next = S_LEG_END;
        else                       w_next = S_RUN;
      end
      S_RUN: begin
        if (r_timer == '0) begin
          cnt_enable = 1'b1;
          w_next     = S_CHECK;
        end
      end
      S_LEG_END: begin
        if (r_bounce && !r_leg_back) w_next = S_CHECK;
        else if (w_pass_last)        w_next = S_DONE;
        else                         w_next = S_LOAD;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_val <= '0;
      r_end_val   <= '0;
      r_bounce    <= 1'b0;
      r_reps      <= '0;
      r_dwell     <= '0;
      r_up        <= 1'b0;
      r_leg_back  <= 1'b0;
      r_target    <= '0;
      r_timer     <= '0;
      r_sweep_idx <= '0;
    end else if (!(abort && (r_state != S_IDLE))) begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_start_val <= cfg_start;
            r_end_val   <= cfg_end;
            r_bounce    <= cfg_bounce;
            r_reps      <= cfg_reps;
            r_dwell     <= cfg_dwell;
            r_up        <= (cfg_end >= cfg_start);
            r_leg_back  <= 1'b0;
            r_target    <= cfg_end;
            r_sweep_idx <= '0;
          end
        end
        S_CHECK: begin
          if (cnt_count != r_target) r_timer <= r_dwell;
        end
        S_RUN: begin
          if (r_timer != '0) r_timer <= r_timer - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
        S_LEG_END: begin
          if (r_bounce && !r_leg_back) begin
            r_leg_back <= 1'b1;
            r_target   <= r_start_val;
          end else begin
            r_sweep_idx <= w_idx_inc;
            r_leg_back  <= 1'b0;
            r_target    <= r_end_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// Bench for counter_sweep_ctrl: attaches a behavioural 4-bit counter and
// checks set/enable/done events against an expected-event queue.
module tb_counter_sweep_ctrl;

  localparam int K_SET  = 0;
  localparam int K_EN   = 1;
  localparam int K_DONE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_start = '0;
  logic [3:0] cfg_end = '0;
  logic       cfg_bounce = 1'b0;
  logic [3:0] cfg_reps = '0;
  logic [7:0] cfg_dwell = '0;
  logic [3:0] cnt_count;
  logic       cnt_enable;
  logic       cnt_set;
  logic [3:0] cnt_set_value;
  logic       cnt_up_down;
  logic       busy;
  logic       done;
  logic [3:0] sweep_idx;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit mon_en = 1'b1;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] val;
    logic       up;
  } evt_t;
  evt_t q[$];

  counter_sweep_ctrl #(.WIDTH(4), .REPS_W(4), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_bounce(cfg_bounce),
    .cfg_reps(cfg_reps), .cfg_dwell(cfg_dwell), .cnt_count(cnt_count),
    .cnt_enable(cnt_enable), .cnt_set(cnt_set), .cnt_set_value(cnt_set_value),
    .cnt_up_down(cnt_up_down), .busy(busy), .done(done), .sweep_idx(sweep_idx)
  );

  always #5 clk = ~clk;

  // attached counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cnt_count <= '0;
    else if (cnt_set)    cnt_count <= cnt_set_value;
    else if (cnt_enable) cnt_count <= cnt_up_down ? cnt_count + 4'd1 : cnt_count - 4'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_evt(input int k, input logic [3:0] v, input logic u);
    evt_t e;
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%0d up=%0d, expected none", k, cyc, v, u);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v || (k != K_DONE && e.up != u)) begin
        mismatched++;
        $display("FAIL event: got kind=%0d cyc=%0d val=%0d up=%0d, expected kind=%0d cyc=%0d val=%0d up=%0d",
                 k, cyc, v, u, e.kind, e.cyc, e.val, e.up);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (cnt_set)    check_evt(K_SET, cnt_set_value, cnt_up_down);
      if (cnt_enable) check_evt(K_EN, cnt_count, cnt_up_down);
      if (done)       check_evt(K_DONE, sweep_idx, 1'b0);
    end
  end

  task automatic push(input int k, input int t, input logic [3:0] v, input logic u);
    evt_t e;
    e.kind = k; e.cyc = t; e.val = v; e.up = u;
    q.push_back(e);
  endtask

  // Timeline of expected events; base is the cycle in which the load is seen.
  task automatic gen(input logic [3:0] s, input logic [3:0] e, input bit b,
                     input int reps, input int dwell, input int base, input int max_en);
    int t; int pass; int nen;
    logic [3:0] cnt; logic [3:0] tgt;
    bit fwd; bit up0; bit up;
    up0 = (e >= s); nen = 0; pass = 0; t = base;
    forever begin
      push(K_SET, t, s, up0);
      cnt = s; fwd = 1'b1; tgt = e; t++;
      forever begin
        while (cnt != tgt) begin
          up = fwd ? up0 : !up0;
          if (nen == max_en) return;
          push(K_EN, t + 1 + dwell, cnt, up);
          nen++;
          cnt = up ? cnt + 4'd1 : cnt - 4'd1;
          t += dwell + 2;
        end
        t++;
        if (b && fwd) begin
          fwd = 1'b0; tgt = s; t++;
        end else break;
      end
      pass++;
      if (reps != 0 && pass == reps) begin
        push(K_DONE, t + 1, 4'(pass), 1'b0);
        return;
      end
      t++;
    end
  endtask

  task automatic run(input logic [3:0] s, input logic [3:0] e, input bit b,
                     input int reps, input int dwell, input int max_en);
    @(negedge clk);
    cfg_start = s; cfg_end = e; cfg_bounce = b;
    cfg_reps = 4'(reps); cfg_dwell = 8'(dwell);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    gen(s, e, b, reps, dwell, cyc, max_en);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", sweep_idx, 0);
    chk("rst_cnt_out", {cnt_enable, cnt_set, cnt_set_value, cnt_up_down}, 0);

    // simple up ramp
    run(4'd2, 4'd5, 1'b0, 1, 0, -1);
    drain("t1");
    chk("t1_busy", busy, 0);
    chk("t1_idx", sweep_idx, 1);
    chk("t1_count", cnt_count, 5);

    // triangle, two passes, down first
    run(4'd9, 4'd6, 1'b1, 2, 1, -1);
    drain("t2");
    chk("t2_idx", sweep_idx, 2);
    chk("t2_count", cnt_count, 9);

    // start equals end
    run(4'd7, 4'd7, 1'b0, 1, 0, -1);
    drain("t3");
    chk("t3_idx", sweep_idx, 1);
    chk("t3_count", cnt_count, 7);

    // endless sweep aborted at count 8
    begin
      int n = 0;
      run(4'd0, 4'd15, 1'b0, 0, 0, 8);
      while (cnt_count != 4'd8 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t4_reach8", cnt_count, 8);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_enable", cnt_enable, 0);
      repeat (20) @(negedge clk);
      chk("t4_count", cnt_count, 8);
      chk("t4_queue", q.size(), 0);
    end

    // start and abort together in IDLE
    @(negedge clk);
    cfg_start = 4'd3; cfg_end = 4'd4; cfg_reps = 4'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t6_count", cnt_count, 8);

    // restart and cfg change while busy are ignored
    run(4'd3, 4'd10, 1'b0, 1, 2, -1);
    repeat (6) @(negedge clk);
    start = 1'b1; cfg_end = 4'd12; cfg_start = 4'd0; cfg_dwell = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    drain("t5");
    chk("t5_idx", sweep_idx, 1);
    chk("t5_count", cnt_count, 10);

    // asynchronous reset mid-sweep
    mon_en = 1'b0;
    run(4'd1, 4'd14, 1'b0, 1, 3, -1);
    q.delete();
    repeat (12) @(negedge clk);
    chk("t5r_busy_pre", busy, 1);
    chk("t5r_up_pre", cnt_up_down, 1);
    reset = 1'b1;
    #1;
    chk("t5r_busy", busy, 0);
    chk("t5r_cnt_out", {cnt_enable, cnt_set, cnt_up_down}, 0);
    chk("t5r_idx", sweep_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run(4'd2, 4'd5, 1'b0, 1, 0, -1);
    drain("t5n");
    chk("t5n_idx", sweep_idx, 1);
    chk("t5n_count", cnt_count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
